add_result_buffer: RTL and testbench

Downstream capture stage for the 4-bit ripple adder. It registers each adder result (4-bit sum plus carry-out) offered on a valid/ready handshake into a small FIFO and drains it to a consumer over a second valid/ready handshake. While buffering, it keeps a running 8-bit total of all accepted results and a saturating count of carry-out events. It sits between the adder's `s`/`overflow` outputs and whatever display or checker logic consumes them.

---
 rtl/add_result_buffer.sv | 116 +++++++++++
 tb/tb_add_result_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_result_buffer.sv
// ============================================================================
// Module  : add_result_buffer
// Purpose : FIFO capture of 4-bit adder results ({carry,sum}) with running
//           8-bit total and saturating carry-out counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_sum,
  input  logic                     in_carry,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_sum,
  output logic                     out_carry,
  output logic [7:0]               total,
  output logic [3:0]               carry_cnt,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [3:0]    CARRY_MAX  = 4'hF;

  logic [4:0]    mem_q [DEPTH];
  logic [4:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    total_q, total_d;
  logic [3:0]    carry_cnt_q, carry_cnt_d;

  logic push;
  logic pop;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  // No pass-through: a same-cycle pop never opens the input when full.
  assign in_ready  = !full && !clear;
  assign out_valid = !empty;
  assign out_sum   = mem_q[rd_ptr_q][3:0];
  assign out_carry = mem_q[rd_ptr_q][4];
  assign total     = total_q;
  assign carry_cnt = carry_cnt_q;
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !clear;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    total_d     = total_q;
    carry_cnt_d = carry_cnt_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      total_d     = '0;
      carry_cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {in_carry, in_sum};
        wr_ptr_d        = wr_ptr_q + 1'b1;
        total_d         = total_q + {3'b000, in_carry, in_sum};
        if (in_carry && (carry_cnt_q != CARRY_MAX)) begin
          carry_cnt_d = carry_cnt_q + 4'd1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      total_q     <= '0;
      carry_cnt_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      total_q     <= total_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_add_result_buffer.sv
// ============================================================================
// Module  : tb_add_result_buffer
// Purpose : Randomized + directed bench for add_result_buffer against a
//           queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_result_buffer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sum;
  logic       in_carry;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_sum;
  logic       out_carry;
  logic [7:0] total;
  logic [3:0] carry_cnt;
  logic [$clog2(DEPTH):0] count;
  logic       full;
  logic       empty;

  add_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .total     (total),
    .carry_cnt (carry_cnt),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: entries as {carry,sum} in arrival order.
  logic [4:0] m_q[$];
  int         m_total;
  int         m_cc;
  bit         chk_en;

  int n_checks;
  int n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_total = 0;
    m_cc    = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] s, input logic c,
                            input logic r, input logic clr);
    bit do_push;
    bit do_pop;
    if (clr) begin
      model_reset();
    end else begin
      do_push = v && (m_q.size() < DEPTH);
      do_pop  = r && (m_q.size() > 0);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back({c, s});
        m_total = (m_total + int'({c, s})) % 256;
        if (c && m_cc < 15) m_cc++;
      end
    end
  endtask

  // One clock cycle: apply inputs, take the edge, advance the model.
  task automatic cycle(input logic v, input logic [3:0] s, input logic c,
                       input logic r, input logic clr);
    in_valid  = v;
    in_sum    = s;
    in_carry  = c;
    out_ready = r;
    clear     = clr;
    @(posedge clk);
    model_step(v, s, c, r, clr);
    #1;
  endtask

  // Compare process: every falling edge, DUT against model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", int'(count), m_q.size());
      check("empty", int'(empty), int'(m_q.size() == 0));
      check("full", int'(full), int'(m_q.size() == DEPTH));
      check("out_valid", int'(out_valid), int'(m_q.size() > 0));
      check("in_ready", int'(in_ready), int'((m_q.size() < DEPTH) && !clear));
      check("total", int'(total), m_total);
      check("carry_cnt", int'(carry_cnt), m_cc);
      if (m_q.size() > 0) begin
        check("out_sum", int'(out_sum), int'(m_q[0][3:0]));
        check("out_carry", int'(out_carry), int'(m_q[0][4]));
      end
    end
  end

  logic [3:0] exp_sums [4];
  logic       exp_cars [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    in_valid = 1'b0; in_sum = '0; in_carry = 1'b0; out_ready = 1'b0; clear = 1'b0;
    rst_n    = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("por_count", int'(count), 0);
    check("por_out_sum", int'(out_sum), 0);
    check("por_out_carry", int'(out_carry), 0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Fill, block, drain.
    cycle(1, 4'd3, 0, 0, 0);
    cycle(1, 4'd15, 1, 0, 0);
    cycle(1, 4'd7, 0, 0, 0);
    cycle(1, 4'd1, 1, 0, 0);
    check("fill_full", int'(full), 1);
    check("fill_in_ready", int'(in_ready), 0);
    check("fill_total", int'(total), 58);
    check("fill_carry_cnt", int'(carry_cnt), 2);
    cycle(1, 4'd9, 0, 0, 0);
    check("blocked_total", int'(total), 58);
    check("blocked_count", int'(count), 4);
    exp_sums[0] = 4'd3;  exp_cars[0] = 1'b0;
    exp_sums[1] = 4'd15; exp_cars[1] = 1'b1;
    exp_sums[2] = 4'd7;  exp_cars[2] = 1'b0;
    exp_sums[3] = 4'd1;  exp_cars[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_sum", int'(out_sum), int'(exp_sums[i]));
      check("drain_carry", int'(out_carry), int'(exp_cars[i]));
      cycle(0, 4'd0, 0, 1, 0);
    end
    check("drain_empty", int'(empty), 1);
    cycle(0, 4'd0, 0, 1, 0);
    check("empty_pop_ignored", int'(count), 0);

    // Streaming at full rate.
    cycle(0, 4'd0, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      cycle(1, 4'(k % 16), 0, 1, 0);
      check("stream_count", int'(count), 1);
      check("stream_lag", int'(out_sum), k % 16);
    end
    check("stream_total", int'(total), 126);

    // Wrap and saturation.
    cycle(0, 4'd0, 0, 0, 1);
    for (int k = 0; k < 20; k++) cycle(1, 4'd15, 1, 1, 0);
    check("wrap_total", int'(total), 108);
    check("wrap_carry_cnt", int'(carry_cnt), 15);

    // Clear priority over push and pop.
    cycle(0, 4'd0, 0, 0, 1);
    cycle(1, 4'd2, 0, 0, 0);
    cycle(1, 4'd4, 1, 0, 0);
    cycle(1, 4'd5, 0, 1, 1);
    check("clr_count", int'(count), 0);
    check("clr_empty", int'(empty), 1);
    check("clr_total", int'(total), 0);
    check("clr_carry_cnt", int'(carry_cnt), 0);
    cycle(0, 4'd0, 0, 0, 0);
    check("clr_not_stored", int'(count), 0);

    // Randomized traffic with occasional clears.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 39) == 0));
    end

    // Asynchronous reset mid-stream with three entries held.
    cycle(0, 4'd0, 0, 0, 1);
    cycle(1, 4'd6, 1, 0, 0);
    cycle(1, 4'd8, 0, 0, 0);
    cycle(1, 4'd9, 1, 0, 0);
    check("pre_rst_count", int'(count), 3);
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_total", int'(total), 0);
    check("rst_carry_cnt", int'(carry_cnt), 0);
    check("rst_out_sum", int'(out_sum), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
